// File: rtl/odd_multiple_bank_if.sv
// Handshake bundle between the odd-multiple bank and its neighbours.
// master: bank producer side; slave: sample source / bank consumer side.
interface odd_multiple_bank_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 12
);
    logic signed [DATA_W-1:0] x_in;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  x1;
    logic signed [OUT_W-1:0]  x3;
    logic signed [OUT_W-1:0]  x5;
    logic signed [OUT_W-1:0]  x7;
    logic signed [OUT_W-1:0]  x9;
    logic signed [OUT_W-1:0]  x11;
    logic signed [OUT_W-1:0]  x13;
    logic signed [OUT_W-1:0]  x15;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;

    modport master (
        input  x_in, in_valid, out_ready,
        output in_ready, out_valid, busy,
        output x1, x3, x5, x7, x9, x11, x13, x15
    );

    modport slave (
        output x_in, in_valid, out_ready,
        input  in_ready, out_valid, busy,
        input  x1, x3, x5, x7, x9, x11, x13, x15
    );
endinterface

// File: rtl/odd_multiple_bank.sv
// Odd-multiple bank x1..x15 of one signed sample, one shared adder,
// double-buffered output that updates atomically on commit.
module odd_multiple_bank #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 12
) (
    input logic                 clk,
    input logic                 resetn,
    odd_multiple_bank_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0] step;

    logic signed [OUT_W-1:0] w1, w3, w5, w7;
    logic signed [OUT_W-1:0] w9, w11, w13, w15;
    logic signed [OUT_W-1:0] b1, b3, b5, b7;
    logic signed [OUT_W-1:0] b9, b11, b13, b15;

    logic signed [OUT_W-1:0] op_a;
    logic signed [OUT_W-1:0] op_b;
    logic signed [OUT_W-1:0] sum;
    logic                    sub;

    logic out_vld;
    logic in_rdy;
    logic bsy;
    logic accept;
    logic free;
    logic commit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = CALC;
            CALC:    if (step == 3'd6)  state_nxt = COMMIT;
            COMMIT:  if (free)          state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy = (state == IDLE);
        bsy    = (state == CALC) || (state == COMMIT);
    end

    assign accept = bus.in_valid & in_rdy;
    assign free   = ~out_vld | bus.out_ready;
    assign commit = (state == COMMIT) & free;

    // Every multiple derives from w1 except 11x and 13x, which reuse 9x.
    always_comb begin
        op_a = '0;
        op_b = w1;
        sub  = 1'b0;
        unique case (step)
            3'd0: op_a = w1 <<< 1;
            3'd1: op_a = w1 <<< 2;
            3'd2: begin op_a = w1 <<< 3; sub = 1'b1; end
            3'd3: op_a = w1 <<< 3;
            3'd4: begin op_a = w9; op_b = w1 <<< 1; end
            3'd5: begin op_a = w9; op_b = w1 <<< 2; end
            3'd6: begin op_a = w1 <<< 4; sub = 1'b1; end
            default: ;
        endcase
    end

    assign sum = sub ? (op_a - op_b) : (op_a + op_b);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step <= '0;
            w1   <= '0;
            w3   <= '0;
            w5   <= '0;
            w7   <= '0;
            w9   <= '0;
            w11  <= '0;
            w13  <= '0;
            w15  <= '0;
        end else if (accept) begin
            step <= '0;
            w1   <= {{(OUT_W-DATA_W){bus.x_in[DATA_W-1]}}, bus.x_in};
        end else if (state == CALC) begin
            step <= step + 3'd1;
            unique case (step)
                3'd0: w3  <= sum;
                3'd1: w5  <= sum;
                3'd2: w7  <= sum;
                3'd3: w9  <= sum;
                3'd4: w11 <= sum;
                3'd5: w13 <= sum;
                3'd6: w15 <= sum;
                default: ;
            endcase
        end
    end

    // Output bank only moves on commit, so consumers never see a partial bank.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_vld <= 1'b0;
            b1      <= '0;
            b3      <= '0;
            b5      <= '0;
            b7      <= '0;
            b9      <= '0;
            b11     <= '0;
            b13     <= '0;
            b15     <= '0;
        end else if (commit) begin
            out_vld <= 1'b1;
            b1      <= w1;
            b3      <= w3;
            b5      <= w5;
            b7      <= w7;
            b9      <= w9;
            b11     <= w11;
            b13     <= w13;
            b15     <= w15;
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.busy      = bsy;
    assign bus.out_valid = out_vld;
    assign bus.x1        = b1;
    assign bus.x3        = b3;
    assign bus.x5        = b5;
    assign bus.x7        = b7;
    assign bus.x9        = b9;
    assign bus.x11       = b11;
    assign bus.x13       = b13;
    assign bus.x15       = b15;

endmodule
